hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Sequences the IF/ID pipeline register and the program counter. Decides each cycle whether the front end advances, holds (stall) or is squashed (flush).
- Handles three hazard sources:
  - load-use data hazards;
  - taken branch/jump redirects;
  - multi-cycle multiply/divide occupancy.
- Sits between the ID/EX decode outputs and the PC, IF/ID and ID/EX control-zeroing logic.

Parameters:
- MULDIV_LATENCY, 4, total cycles a mul/div occupies EX; the front end holds for MULDIV_LATENCY-1 cycles after issue (legal 2..16).
- FLUSH_CYCLES, 1, cycles IFIDFlush stays asserted after a taken redirect (legal 1..3).
- REG_ADDR_W, 5, register specifier width.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- IDRs  in  REG_ADDR_W  rs field of the instruction in ID.
- IDRt  in  REG_ADDR_W  rt field of the instruction in ID.
- IDUsesRt  in  1  ID instruction reads rt as a source.
- EXMemRead  in  1  instruction in EX is a load.
- EXRt  in  REG_ADDR_W  destination of the load in EX.
- EXMulDivStart  in  1  a mul/div entered EX this cycle.
- BranchTaken  in  1  redirect resolved this cycle (taken branch or jump).
- PCWrite  out  1  PC may update.
- IFIDWrite  out  1  IF/ID register may capture.
- IFIDFlush  out  1  zero IF/ID contents.
- IDEXBubble  out  1  zero the ID/EX control fields (insert NOP).
- Busy  out  1  controller is in any non-RUN state.

Behaviour:
- States: RUN, LOAD_STALL, MULDIV_STALL, FLUSH. State register and down-counter cnt (4 bits) reset asynchronously to RUN / 0.
- Reset values: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0, Busy=0. Outputs are a pure function of state, cnt and the current inputs, so they react in the same cycle as the hazard.
- Load-use hazard is detected when all of the following hold:
  - EXMemRead=1;
  - EXRt!=0;
  - EXRt==IDRs, or (IDUsesRt and EXRt==IDRt).
- Event priority, evaluated in any state: BranchTaken > active MULDIV_STALL > load-use > none.
- RUN:
  - No event: PCWrite=IFIDWrite=1, IFIDFlush=IDEXBubble=0.
  - BranchTaken: IFIDFlush=1 and IDEXBubble=1 this cycle. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  - EXMulDivStart (without BranchTaken): PCWrite=IFIDWrite=0 and IDEXBubble=1 this cycle. Go to MULDIV_STALL with cnt=MULDIV_LATENCY-2. If MULDIV_LATENCY=2, stay in RUN.
  - Load-use: PCWrite=IFIDWrite=0 and IDEXBubble=1 for exactly this cycle. Go to LOAD_STALL.
- LOAD_STALL:
  - Outputs as in RUN with no event. The bubble has moved the load to MEM, so the hazard clears.
  - Return to RUN next cycle.
  - A second load-use detected here stalls again. This is legal and must not deadlock, because EX holds a bubble.
- MULDIV_STALL:
  - PCWrite=IFIDWrite=0, IDEXBubble=1.
  - cnt decrements each cycle; leave to RUN on the cycle after cnt reaches 0.
  - Load-use is ignored here. BranchTaken is not expected here; if asserted, flush takes priority and the state goes to FLUSH/RUN, abandoning the stall.
- FLUSH:
  - IFIDFlush=1, IDEXBubble=1, PCWrite=1 so the redirect target keeps fetching.
  - cnt decrements; go to RUN after cnt hits 0.
  - A new BranchTaken reloads cnt.
- Simultaneous BranchTaken and load-use: flush only, no stall. The squashed instruction's hazard is void.
- Simultaneous EXMulDivStart and load-use: MULDIV_STALL wins and load-use is subsumed.
- Rst_n low at any point, including mid-stall: immediate return to RUN with reset output values. No stall is carried over.
- Busy=1 iff state!=RUN.

Optional Feature:
- HAZARD_STATS_EN defined:
  - Adds outputs StallCount[31:0] and FlushCount[31:0].
  - StallCount increments on every cycle with PCWrite=0.
  - FlushCount increments on every cycle with IFIDFlush=1.
  - Both counters wrap at 2^32, reset to 0 on Rst_n, and are marked for debug visibility.
- HAZARD_STATS_EN undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg holds:
  - state encoding typedef hz_state_t {RUN=2'b00, LOAD_STALL=2'b01, MULDIV_STALL=2'b10, FLUSH=2'b11};
  - REG_ADDR_W default;
  - ZERO_REG constant (0).
- One sub-module, load_use_detect: combinational comparator producing the load-use hit flag. Reused later for forwarding checks.
- The FSM, counter and output decode stay in hazard_stall_controller.

Test Plan:
- Reset: Rst_n=0 then 1, no events -> PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0, Busy=0.
- Load-use: EXMemRead=1, EXRt=5, IDRs=5 -> exactly one cycle of PCWrite=IFIDWrite=0 and IDEXBubble=1, Busy=1 the next cycle, then RUN. Repeat with EXRt=0 -> no stall. Repeat with IDRt=5, IDUsesRt=0 -> no stall.
- Mul/div: MULDIV_LATENCY=4, pulse EXMulDivStart -> PCWrite=0 for exactly 3 consecutive cycles, then 1. Rst_n pulsed in the 2nd stall cycle -> PCWrite=1 immediately and state RUN.
- Branch flush: FLUSH_CYCLES=2, pulse BranchTaken -> IFIDFlush=1 for 2 cycles with PCWrite=1 throughout. BranchTaken together with load-use (EXRt=IDRs=7) -> IFIDFlush=1, PCWrite=1, no stall cycle.
- Back-to-back: load-use in two consecutive cycles -> two single-cycle stalls, no deadlock. BranchTaken in FLUSH cycle 1 -> flush extended to 2 further cycles.
- HAZARD_STATS_EN: run the mul/div case followed by one branch with FLUSH_CYCLES=1 -> StallCount=3, FlushCount=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the front-end hazard/stall controller: state encoding,
// default register-specifier width and the hardwired-zero register number.
package hazard_pkg;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int ZERO_REG       = 0;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        RUN          = 2'b00,
        LOAD_STALL   = 2'b01,
        MULDIV_STALL = 2'b10,
        FLUSH        = 2'b11
    } hz_state_t;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Decode-side inputs and front-end control outputs of the hazard controller.
// With HAZARD_STATS_EN defined the interface also carries the stall/flush counters.
interface hazard_stall_controller_if
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
);
    logic [REG_ADDR_W-1:0] IDRs;
    logic [REG_ADDR_W-1:0] IDRt;
    logic                  IDUsesRt;
    logic                  EXMemRead;
    logic [REG_ADDR_W-1:0] EXRt;
    logic                  EXMulDivStart;
    logic                  BranchTaken;

    logic                  PCWrite;
    logic                  IFIDWrite;
    logic                  IFIDFlush;
    logic                  IDEXBubble;
    logic                  Busy;
`ifdef HAZARD_STATS_EN
    logic [31:0]           StallCount;
    logic [31:0]           FlushCount;
`endif

    // master: pipeline decode side; slave: the controller
    modport master (
        output IDRs, IDRt, IDUsesRt, EXMemRead, EXRt, EXMulDivStart, BranchTaken,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, Busy
`ifdef HAZARD_STATS_EN
        , input StallCount, FlushCount
`endif
    );

    modport slave (
        input  IDRs, IDRt, IDUsesRt, EXMemRead, EXRt, EXMulDivStart, BranchTaken,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, Busy
`ifdef HAZARD_STATS_EN
        , output StallCount, FlushCount
`endif
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID source that matches the
// destination of a load sitting in EX (register zero never counts).
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  i_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_rt,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_id_uses_rt,
    output logic                  o_hit
);

    logic w_rs_match;
    logic w_rt_match;
    logic w_dest_valid;

    assign w_dest_valid = (i_ex_rt != REG_ADDR_W'(ZERO_REG));
    assign w_rs_match   = (i_ex_rt == i_id_rs);
    assign w_rt_match   = i_id_uses_rt && (i_ex_rt == i_id_rt);
    assign o_hit        = i_mem_read && w_dest_valid && (w_rs_match || w_rt_match);

endmodule

// File: rtl/hazard_stall_controller.sv
// Front-end hazard controller: decides advance / stall / flush of PC and IF/ID.
// Optional macro HAZARD_STATS_EN adds free-running stall and flush cycle counters.
//
//   state        | meaning
//   RUN          | no hazard pending, front end advances unless a new event hits
//   LOAD_STALL   | one bubble inserted behind a load; load now in MEM
//   MULDIV_STALL | front end held while mul/div occupies EX; cnt counts down
//   FLUSH        | IF/ID squashed after a redirect; cnt counts down
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4,
    parameter int FLUSH_CYCLES   = 1,
    parameter int REG_ADDR_W     = DEF_REG_ADDR_W
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    hazard_stall_controller_if.slave  hz
);

    localparam logic [CNT_W-1:0] MD_RELOAD = CNT_W'(MULDIV_LATENCY - 2);
    localparam logic [CNT_W-1:0] FL_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    hz_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;

    hz_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_load_use;
    logic             w_pc_write;
    logic             w_ifid_write;
    logic             w_ifid_flush;
    logic             w_idex_bubble;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .i_mem_read   (hz.EXMemRead),
        .i_ex_rt      (hz.EXRt),
        .i_id_rs      (hz.IDRs),
        .i_id_rt      (hz.IDRt),
        .i_id_uses_rt (hz.IDUsesRt),
        .o_hit        (w_load_use)
    );

    // A redirect squashes the ID instruction, so it overrides every other event.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;

        if (hz.BranchTaken) begin
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_state_nxt = FLUSH;
                w_cnt_nxt   = FL_RELOAD;
            end else begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end
        end else begin
            case (r_state)
                MULDIV_STALL: begin
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_idex_bubble = 1'b1;
                    if (r_cnt <= CNT_ONE) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt - CNT_ONE;
                    end
                end
                FLUSH: begin
                    w_ifid_flush  = 1'b1;
                    w_idex_bubble = 1'b1;
                    if (r_cnt <= CNT_ONE) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    // RUN and LOAD_STALL share decode: a repeat load-use in
                    // LOAD_STALL just stalls again since EX now holds a bubble.
                    if (hz.EXMulDivStart) begin
                        w_pc_write    = 1'b0;
                        w_ifid_write  = 1'b0;
                        w_idex_bubble = 1'b1;
                        if (MULDIV_LATENCY > 2) begin
                            w_state_nxt = MULDIV_STALL;
                            w_cnt_nxt   = MD_RELOAD;
                        end else begin
                            w_state_nxt = RUN;
                            w_cnt_nxt   = '0;
                        end
                    end else if (w_load_use) begin
                        w_pc_write    = 1'b0;
                        w_ifid_write  = 1'b0;
                        w_idex_bubble = 1'b1;
                        w_state_nxt   = LOAD_STALL;
                        w_cnt_nxt     = '0;
                    end else begin
                        w_state_nxt   = RUN;
                        w_cnt_nxt     = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign hz.PCWrite    = w_pc_write;
    assign hz.IFIDWrite  = w_ifid_write;
    assign hz.IFIDFlush  = w_ifid_flush;
    assign hz.IDEXBubble = w_idex_bubble;
    assign hz.Busy       = (r_state != RUN);

`ifdef HAZARD_STATS_EN
    (* mark_debug = "true" *) logic [31:0] r_stall_count;
    (* mark_debug = "true" *) logic [31:0] r_flush_count;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (!w_pc_write) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (w_ifid_flush) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign hz.StallCount = r_stall_count;
    assign hz.FlushCount = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: table of per-cycle vectors plus
// hand sequences for async reset mid-stall and the single-cycle-flush build.
module tb_hazard_stall_controller;

    localparam int W = 5;

    typedef struct {
        string        name;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic         uses_rt;
        logic         mem_rd;
        logic [W-1:0] ex_rt;
        logic         mds;
        logic         br;
        logic [4:0]   exp;   // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, Busy}
    } vec_t;

    logic Clk;
    logic Rst_n;
    int   checks;
    int   failures;
    vec_t tbl[$];
    vec_t dut1_seq[$];

    hazard_stall_controller_if #(.REG_ADDR_W(W)) hz_a ();
    hazard_stall_controller_if #(.REG_ADDR_W(W)) hz_b ();

    hazard_stall_controller #(
        .MULDIV_LATENCY (4),
        .FLUSH_CYCLES   (2),
        .REG_ADDR_W     (W)
    ) u_dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .hz    (hz_a.slave)
    );

    hazard_stall_controller #(
        .MULDIV_LATENCY (4),
        .FLUSH_CYCLES   (1),
        .REG_ADDR_W     (W)
    ) u_dut_f1 (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .hz    (hz_b.slave)
    );

    logic [4:0] w_out_a;
    logic [4:0] w_out_b;
    assign w_out_a = {hz_a.PCWrite, hz_a.IFIDWrite, hz_a.IFIDFlush, hz_a.IDEXBubble, hz_a.Busy};
    assign w_out_b = {hz_b.PCWrite, hz_b.IFIDWrite, hz_b.IFIDFlush, hz_b.IDEXBubble, hz_b.Busy};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic vec_t mk(input string n, input logic [W-1:0] rs, input logic [W-1:0] rt,
                                input logic ur, input logic mr, input logic [W-1:0] ert,
                                input logic md, input logic br, input logic [4:0] e);
        vec_t v;
        v.name = n; v.rs = rs; v.rt = rt; v.uses_rt = ur; v.mem_rd = mr;
        v.ex_rt = ert; v.mds = md; v.br = br; v.exp = e;
        return v;
    endfunction

    function automatic vec_t idle(input string n, input logic [4:0] e);
        return mk(n, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, e);
    endfunction

    function automatic vec_t lu(input string n, input logic [W-1:0] r, input logic [4:0] e);
        return mk(n, r, 5'd0, 1'b0, 1'b1, r, 1'b0, 1'b0, e);
    endfunction

    task automatic check(input string n, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got={pcw,ifw,flush,bub,busy}=%b expected=%b", n, got, exp);
        end
    endtask

    task automatic check32(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", n, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input vec_t v);
        if (!sel) begin
            hz_a.IDRs = v.rs; hz_a.IDRt = v.rt; hz_a.IDUsesRt = v.uses_rt;
            hz_a.EXMemRead = v.mem_rd; hz_a.EXRt = v.ex_rt;
            hz_a.EXMulDivStart = v.mds; hz_a.BranchTaken = v.br;
        end else begin
            hz_b.IDRs = v.rs; hz_b.IDRt = v.rt; hz_b.IDUsesRt = v.uses_rt;
            hz_b.EXMemRead = v.mem_rd; hz_b.EXRt = v.ex_rt;
            hz_b.EXMulDivStart = v.mds; hz_b.BranchTaken = v.br;
        end
    endtask

    // Inputs are applied just after a rising edge and outputs checked on the falling edge.
    task automatic run_vec(input bit sel, input vec_t v);
        drive(sel, v);
        @(negedge Clk);
        check(v.name, sel ? w_out_b : w_out_a, v.exp);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // load-use basics
        tbl.push_back(idle("run_idle",          5'b11000));
        tbl.push_back(lu  ("lu_rs_stall",  5'd5, 5'b00010));
        tbl.push_back(idle("lu_rs_release",     5'b11001));
        tbl.push_back(idle("lu_rs_back_run",    5'b11000));
        tbl.push_back(lu  ("lu_zero_reg",  5'd0, 5'b11000));
        tbl.push_back(mk("lu_rt_unused", 5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 5'b11000));
        tbl.push_back(mk("lu_rt_used",   5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'b00010));
        tbl.push_back(idle("lu_rt_release",     5'b11001));
        tbl.push_back(idle("lu_rt_back_run",    5'b11000));
        // back-to-back load-use
        tbl.push_back(lu  ("b2b_lu_1",     5'd6, 5'b00010));
        tbl.push_back(lu  ("b2b_lu_2",     5'd6, 5'b00011));
        tbl.push_back(idle("b2b_release",       5'b11001));
        tbl.push_back(idle("b2b_back_run",      5'b11000));
        // mul/div, latency 4: three stall cycles
        tbl.push_back(mk("md_issue", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'b00010));
        tbl.push_back(idle("md_stall_2",        5'b00011));
        tbl.push_back(idle("md_stall_3",        5'b00011));
        tbl.push_back(idle("md_done",           5'b11000));
        // mul/div together with load-use: mul/div wins, load-use ignored while stalled
        tbl.push_back(mk("md_lu_issue", 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 5'b00010));
        tbl.push_back(lu  ("md_lu_stall_2", 5'd4, 5'b00011));
        tbl.push_back(idle("md_lu_stall_3",     5'b00011));
        tbl.push_back(idle("md_lu_done",        5'b11000));
        // branch flush, two cycles
        tbl.push_back(mk("br_taken", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'b11110));
        tbl.push_back(idle("br_flush_2",        5'b11111));
        tbl.push_back(idle("br_done",           5'b11000));
        // branch with load-use: flush only
        tbl.push_back(mk("br_lu", 5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 5'b11110));
        tbl.push_back(idle("br_lu_flush_2",     5'b11111));
        tbl.push_back(idle("br_lu_done",        5'b11000));
        // second branch during FLUSH reloads the counter
        tbl.push_back(mk("br_ext_1", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'b11110));
        tbl.push_back(mk("br_ext_2", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'b11111));
        tbl.push_back(idle("br_ext_3",          5'b11111));
        tbl.push_back(idle("br_ext_done",       5'b11000));
        // branch abandons a mul/div stall
        tbl.push_back(mk("md_br_issue", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'b00010));
        tbl.push_back(mk("md_br_taken", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'b11111));
        tbl.push_back(idle("md_br_flush_2",     5'b11111));
        tbl.push_back(idle("md_br_done",        5'b11000));

        // single-cycle flush build: mul/div then one branch
        dut1_seq.push_back(mk("f1_md_issue", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'b00010));
        dut1_seq.push_back(idle("f1_md_stall_2",    5'b00011));
        dut1_seq.push_back(idle("f1_md_stall_3",    5'b00011));
        dut1_seq.push_back(idle("f1_md_done",       5'b11000));
        dut1_seq.push_back(mk("f1_br_taken", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'b11110));
        dut1_seq.push_back(idle("f1_br_done",       5'b11000));

        drive(1'b0, idle("init", 5'b0));
        drive(1'b1, idle("init", 5'b0));
        Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset_hold_a", w_out_a, 5'b11000);
        check("reset_hold_b", w_out_b, 5'b11000);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        foreach (tbl[i]) run_vec(1'b0, tbl[i]);

        // async reset in the second mul/div stall cycle
        drive(1'b0, mk("x", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'b0));
        @(negedge Clk);
        check("rst_md_issue", w_out_a, 5'b00010);
        @(posedge Clk);
        #1;
        drive(1'b0, idle("x", 5'b0));
        #2;
        check("rst_md_stall_2", w_out_a, 5'b00011);
        Rst_n = 1'b0;
        #1;
        check("rst_mid_stall", w_out_a, 5'b11000);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        run_vec(1'b0, idle("rst_no_carry", 5'b11000));

        foreach (dut1_seq[i]) run_vec(1'b1, dut1_seq[i]);

`ifdef HAZARD_STATS_EN
        check32("stall_count", hz_b.StallCount, 32'd3);
        check32("flush_count", hz_b.FlushCount, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
